// File: rtl/stage3_prefetch_queue_pkg.sv
// stage3_prefetch_queue_pkg: fetched-instruction entry type shared by the prefetch queue and its FIFO
package stage3_prefetch_queue_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        mal;
    logic        fault;
    logic [31:0] badaddr;
  } fetch_entry_t;
  function automatic fetch_entry_t mk_entry(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic pred, input logic mal, input logic fault);
    return '{instr: instr, pc: pc, pc4: pc + 32'd4, pred: pred, mal: mal, fault: fault, badaddr: pc};
  endfunction
endpackage

// File: rtl/stage3_prefetch_queue_if.sv
// stage3_prefetch_queue_if: redirect, instruction bus, predictor and execute-side signals of the fetch unit
interface stage3_prefetch_queue_if #(parameter int DEPTH = 4);
  localparam int PTR_W = $clog2(DEPTH);
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      bus_addr;
  logic             bus_ren;
  logic [31:0]      bus_rdata;
  logic             bus_busy;
  logic             bus_error;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc4;
  logic             out_pred;
  logic             out_mal;
  logic             out_fault;
  logic [31:0]      out_badaddr;
  logic [PTR_W:0]   occupancy;
  modport master (
    input  redirect, redirect_pc, bus_rdata, bus_busy, bus_error, pred_taken, pred_target, out_ready,
    output bus_addr, bus_ren, pred_pc, out_valid, out_instr, out_pc, out_pc4, out_pred, out_mal,
           out_fault, out_badaddr, occupancy
  );
  modport slave (
    output redirect, redirect_pc, bus_rdata, bus_busy, bus_error, pred_taken, pred_target, out_ready,
    input  bus_addr, bus_ren, pred_pc, out_valid, out_instr, out_pc, out_pc4, out_pred, out_mal,
           out_fault, out_badaddr, occupancy
  );
endinterface

// File: rtl/stage3_fetch_fifo.sv
// stage3_fetch_fifo: DEPTH-entry fetch_entry_t FIFO with push/pop, flush and occupancy count
module stage3_fetch_fifo
  import stage3_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  fetch_entry_t   din_i,
  output fetch_entry_t   dout_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);
  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [PTR_W:0]   cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1;
      end
      if (pop_i) rd_q <= rd_q + 1;
      cnt_q <= (push_i && !pop_i) ? cnt_q + 1 : (!push_i && pop_i) ? cnt_q - 1 : cnt_q;
    end
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/stage3_prefetch_queue.sv
// stage3_prefetch_queue: decoupled fetch unit filling a DEPTH-entry queue ahead of execute, with redirect discard.
// Define STAGE3_PREFETCH_BYPASS_EN to forward a completion straight to out_* when the queue is empty.
module stage3_prefetch_queue
  import stage3_prefetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          DEPTH    = 4
) (
  input logic                     CLK,
  input logic                     RST,
  stage3_prefetch_queue_if.master io
);
  logic [31:0]          fetch_pc_q, fetch_pc_d, old_addr_q;
  logic                 pending_q, pending_d, discard_q, discard_d, halted_q, halted_d;
  logic                 issue_ok, ren, done, push_fetch, mis, push, pop, byp, valid, full, empty;
  fetch_entry_t         push_entry, head, out_e;
  logic [$clog2(DEPTH):0] cnt;
  always_comb begin
    issue_ok   = !halted_q && fetch_pc_q[1:0] == 2'b00 && (pending_q || !full);
    ren        = !RST && (discard_q || issue_ok);
    done       = ren && !io.bus_busy;
    push_fetch = done && !discard_q;
    mis        = !RST && !discard_q && !halted_q && fetch_pc_q[1:0] != 2'b00 && !full;
    push_entry = mis ? mk_entry(fetch_pc_q, 32'd0, 1'b0, 1'b1, 1'b0)
                     : mk_entry(fetch_pc_q, io.bus_error ? 32'd0 : io.bus_rdata, io.pred_taken, 1'b0, io.bus_error);
`ifdef STAGE3_PREFETCH_BYPASS_EN
    byp        = empty && push_fetch && !io.redirect;
`else
    byp        = 1'b0;
`endif
    valid      = !RST && (!empty || byp);
    pop        = valid && !empty && io.out_ready && !io.redirect;
    push       = (push_fetch || mis) && !io.redirect && !(byp && io.out_ready);
    out_e      = byp ? push_entry : head;
    fetch_pc_d = io.redirect ? io.redirect_pc
               : push_fetch ? (io.pred_taken ? io.pred_target : fetch_pc_q + 32'd4) : fetch_pc_q;
    halted_d   = !io.redirect && (halted_q || mis || (push_fetch && io.bus_error));
    // an in-flight access hit by a redirect keeps running on its old address until it completes
    discard_d  = (discard_q || io.redirect) && ren && io.bus_busy;
    pending_d  = ren && io.bus_busy;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      old_addr_q <= '0;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      old_addr_q <= io.bus_addr;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
    end
  end
  stage3_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .flush_i(io.redirect), .push_i(push), .pop_i(pop), .din_i(push_entry),
    .dout_o(head), .count_o(cnt), .full_o(full), .empty_o(empty)
  );
  assign io.bus_ren     = ren;
  assign io.bus_addr    = discard_q ? old_addr_q : fetch_pc_q;
  assign io.pred_pc     = fetch_pc_q;
  assign io.out_valid   = valid;
  assign io.out_instr   = out_e.instr;
  assign io.out_pc      = out_e.pc;
  assign io.out_pc4     = out_e.pc4;
  assign io.out_pred    = out_e.pred;
  assign io.out_mal     = out_e.mal;
  assign io.out_fault   = out_e.fault;
  assign io.out_badaddr = out_e.badaddr;
  assign io.occupancy   = cnt;
endmodule

// File: tb/tb_stage3_prefetch_queue.sv
// tb_stage3_prefetch_queue: scoreboard bench for the prefetch queue with a zero-wait memory model
module tb_stage3_prefetch_queue;
  import stage3_prefetch_queue_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  stage3_prefetch_queue_if #(.DEPTH(4)) ifc ();
  stage3_prefetch_queue #(.RESET_PC(32'h80000000), .DEPTH(4)) dut (.CLK(CLK), .RST(RST), .io(ifc));
  int chk = 0, err = 0, n_pop = 0;
  fetch_entry_t exp_q[$];
  logic [31:0] pred_at = 32'h0, err_addr = 32'hFFFF_FFFF;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0013;
  endfunction
  assign ifc.bus_rdata   = mem(ifc.bus_addr);
  assign ifc.bus_error   = ifc.bus_addr == err_addr;
  assign ifc.pred_taken  = ifc.pred_pc == pred_at;
  assign ifc.pred_target = 32'h80000040;
  function automatic fetch_entry_t ent(input logic [31:0] pc, input logic pred, input logic mal, input logic fault);
    fetch_entry_t e;
    e.instr = (mal || fault) ? 32'd0 : mem(pc);
    e.pc = pc; e.pc4 = pc + 32'd4; e.pred = pred; e.mal = mal; e.fault = fault; e.badaddr = pc;
    return e;
  endfunction
  task automatic push_seq(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ent(pc + 32'(4 * i), 1'b0, 1'b0, 1'b0));
  endtask
  task automatic cyc();
    @(posedge CLK); #1;
  endtask
  task automatic do_redirect(input logic [31:0] pc);
    ifc.redirect = 1'b1; ifc.redirect_pc = pc; exp_q.delete();
    cyc();
    ifc.redirect = 1'b0;
  endtask
  always @(negedge CLK) begin
    fetch_entry_t got, want;
    if (!RST && !ifc.redirect && ifc.out_valid && ifc.out_ready) begin
      got = '{instr: ifc.out_instr, pc: ifc.out_pc, pc4: ifc.out_pc4, pred: ifc.out_pred,
              mal: ifc.out_mal, fault: ifc.out_fault, badaddr: ifc.out_badaddr};
      n_pop++; chk++;
      if (exp_q.size() == 0) begin
        err++; $display("FAIL head_unexpected: got pc=%h, required no output", got.pc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          err++;
          $display("FAIL head_entry: got pc=%h instr=%h pc4=%h pred=%b mal=%b fault=%b bad=%h, required pc=%h instr=%h pc4=%h pred=%b mal=%b fault=%b bad=%h",
                   got.pc, got.instr, got.pc4, got.pred, got.mal, got.fault, got.badaddr,
                   want.pc, want.instr, want.pc4, want.pred, want.mal, want.fault, want.badaddr);
        end
      end
    end
  end
  task automatic test_reset();
    cyc(); cyc();
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b0) begin err++; $display("FAIL reset_ren: got %b required 0", ifc.bus_ren); end
    chk++; if (ifc.out_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b required 0", ifc.out_valid); end
    chk++; if (ifc.occupancy !== 3'd0) begin err++; $display("FAIL reset_occ: got %0d required 0", ifc.occupancy); end
    cyc();
    RST = 1'b0;
    push_seq(32'h80000000, 4);
  endtask
  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk++;
      if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000000 + 32'(4 * k)) begin
        err++; $display("FAIL fill_addr: got ren=%b addr=%h required ren=1 addr=%h", ifc.bus_ren, ifc.bus_addr, 32'h80000000 + 32'(4 * k));
      end
      cyc();
    end
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b0) begin err++; $display("FAIL fill_full_ren: got %b required 0", ifc.bus_ren); end
    chk++; if (ifc.occupancy !== 3'd4) begin err++; $display("FAIL fill_occ: got %0d required 4", ifc.occupancy); end
    chk++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h80000000) begin err++; $display("FAIL fill_head: got valid=%b pc=%h required valid=1 pc=80000000", ifc.out_valid, ifc.out_pc); end
    cyc();
  endtask
  task automatic test_back_to_back();
    int p0;
    push_seq(32'h80000010, 20);
    ifc.out_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk++;
      if (ifc.occupancy !== ((i == 0) ? 3'd4 : 3'd3)) begin err++; $display("FAIL b2b_occ: cycle %0d got %0d required %0d", i, ifc.occupancy, (i == 0) ? 4 : 3); end
      if (i > 0) begin
        chk++;
        if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000010 + 32'(4 * (i - 1))) begin
          err++; $display("FAIL b2b_addr: cycle %0d got ren=%b addr=%h required ren=1 addr=%h", i, ifc.bus_ren, ifc.bus_addr, 32'h80000010 + 32'(4 * (i - 1)));
        end
      end
      cyc();
    end
    ifc.out_ready = 1'b0;
    chk++; if (n_pop - p0 != 12) begin err++; $display("FAIL b2b_rate: got %0d pops required 12", n_pop - p0); end
  endtask
  task automatic test_redirect_discard();
    do_redirect(32'h80000000);
    push_seq(32'h80000000, 2);
    cyc(); cyc();
    ifc.bus_busy = 1'b1;
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000008) begin err++; $display("FAIL disc_start: got ren=%b addr=%h required ren=1 addr=80000008", ifc.bus_ren, ifc.bus_addr); end
    cyc();
    ifc.redirect = 1'b1; ifc.redirect_pc = 32'h80000100; exp_q.delete();
    @(negedge CLK);
    chk++; if (ifc.bus_addr !== 32'h80000008) begin err++; $display("FAIL disc_redir_addr: got %h required 80000008", ifc.bus_addr); end
    cyc();
    ifc.redirect = 1'b0;
    push_seq(32'h80000100, 8);
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000008) begin err++; $display("FAIL disc_hold: got ren=%b addr=%h required ren=1 addr=80000008", ifc.bus_ren, ifc.bus_addr); end
    chk++; if (ifc.occupancy !== 3'd0) begin err++; $display("FAIL disc_occ: got %0d required 0", ifc.occupancy); end
    cyc();
    ifc.bus_busy = 1'b0;
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000008) begin err++; $display("FAIL disc_done_addr: got ren=%b addr=%h required ren=1 addr=80000008", ifc.bus_ren, ifc.bus_addr); end
    cyc();
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b1 || ifc.bus_addr !== 32'h80000100) begin err++; $display("FAIL disc_resume: got ren=%b addr=%h required ren=1 addr=80000100", ifc.bus_ren, ifc.bus_addr); end
    chk++; if (ifc.occupancy !== 3'd0) begin err++; $display("FAIL disc_dropped: got occ %0d required 0", ifc.occupancy); end
    cyc();
    @(negedge CLK);
    chk++; if (ifc.occupancy !== 3'd1 || ifc.out_pc !== 32'h80000100) begin err++; $display("FAIL disc_first: got occ=%0d pc=%h required occ=1 pc=80000100", ifc.occupancy, ifc.out_pc); end
    cyc();
    ifc.out_ready = 1'b1;
    cyc(); cyc(); cyc();
    ifc.out_ready = 1'b0;
  endtask
  task automatic test_pred();
    pred_at = 32'h80000004;
    do_redirect(32'h80000000);
    exp_q.push_back(ent(32'h80000000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h80000004, 1'b1, 1'b0, 1'b0));
    push_seq(32'h80000040, 10);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk++;
      if (ifc.bus_addr !== ((k < 2) ? 32'h80000000 + 32'(4 * k) : 32'h80000040 + 32'(4 * (k - 2)))) begin
        err++; $display("FAIL pred_addr: step %0d got %h", k, ifc.bus_addr);
      end
      cyc();
    end
    ifc.out_ready = 1'b1;
    cyc();
    @(negedge CLK);
    chk++; if (ifc.out_pc !== 32'h80000004 || ifc.out_pred !== 1'b1 || ifc.out_pc4 !== 32'h80000008) begin
      err++; $display("FAIL pred_entry: got pc=%h pred=%b pc4=%h required pc=80000004 pred=1 pc4=80000008", ifc.out_pc, ifc.out_pred, ifc.out_pc4);
    end
    cyc(); cyc(); cyc();
    ifc.out_ready = 1'b0;
    pred_at = 32'h0;
  endtask
  task automatic test_error();
    err_addr = 32'h80000010;
    do_redirect(32'h80000008);
    exp_q.push_back(ent(32'h80000008, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h8000000C, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(32'h80000010, 1'b0, 1'b0, 1'b1));
    cyc(); cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk++; if (ifc.bus_ren !== 1'b0 || ifc.occupancy !== 3'd3) begin err++; $display("FAIL err_halt: got ren=%b occ=%0d required ren=0 occ=3", ifc.bus_ren, ifc.occupancy); end
      cyc();
    end
    ifc.out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    @(negedge CLK);
    chk++; if (ifc.out_valid !== 1'b0 || ifc.bus_ren !== 1'b0) begin err++; $display("FAIL err_drained: got valid=%b ren=%b required valid=0 ren=0", ifc.out_valid, ifc.bus_ren); end
    chk++; if (exp_q.size() != 0) begin err++; $display("FAIL err_outputs: got %0d left required 0", exp_q.size()); end
    cyc();
    ifc.out_ready = 1'b0;
    err_addr = 32'hFFFF_FFFF;
  endtask
  task automatic test_misaligned();
    do_redirect(32'h80000102);
    exp_q.push_back(ent(32'h80000102, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    chk++; if (ifc.bus_ren !== 1'b0) begin err++; $display("FAIL mal_noaccess: got ren=%b required 0", ifc.bus_ren); end
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk++;
      if (ifc.bus_ren !== 1'b0 || ifc.occupancy !== 3'd1 || ifc.out_mal !== 1'b1 || ifc.out_badaddr !== 32'h80000102 || ifc.out_instr !== 32'd0) begin
        err++; $display("FAIL mal_entry: got ren=%b occ=%0d mal=%b bad=%h instr=%h required ren=0 occ=1 mal=1 bad=80000102 instr=0",
                        ifc.bus_ren, ifc.occupancy, ifc.out_mal, ifc.out_badaddr, ifc.out_instr);
      end
      cyc();
    end
    ifc.out_ready = 1'b1;
    cyc();
    @(negedge CLK);
    chk++; if (ifc.out_valid !== 1'b0 || ifc.bus_ren !== 1'b0) begin err++; $display("FAIL mal_halted: got valid=%b ren=%b required 0 0", ifc.out_valid, ifc.bus_ren); end
    cyc();
    ifc.out_ready = 1'b0;
  endtask
  initial begin
    ifc.redirect = 1'b0; ifc.redirect_pc = 32'h0; ifc.bus_busy = 1'b0; ifc.out_ready = 1'b0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_redirect_discard();
    test_pred();
    test_error();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
